// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - control codes, byte classes, FSM states and cell addressing for the text buffer
package vga_text_pkg;

  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} txt_state_e;

  typedef enum logic [2:0] {
    CLS_OTHER,
    CLS_PRINT,
    CLS_LF,
    CLS_BS,
    CLS_FF
  } char_class_e;

  function automatic int cell_lsb(input int row, input int col, input int columns);
    return (row * columns + col) * 8;
  endfunction

  function automatic char_class_e classify(input logic [7:0] ch);
    if (ch >= CH_PRINT_LO && ch <= CH_PRINT_HI) return CLS_PRINT;
    else if (ch == CH_LF) return CLS_LF;
    else if (ch == CH_BS) return CLS_BS;
    else if (ch == CH_FF) return CLS_FF;
    else return CLS_OTHER;
  endfunction

endpackage

// File: rtl/text_cursor_tracker.sv
// rtl/text_cursor_tracker.sv - cursor registers plus next-position, write-target and scroll-request decode
module text_cursor_tracker
  import vga_text_pkg::*;
#(
  parameter int COLUMNS = 16,
  parameter int ROWS    = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        i_step,
  input  logic [2:0]                  i_class,
  output logic [$clog2(COLUMNS)-1:0]  o_col,
  output logic [$clog2(ROWS)-1:0]     o_row,
  output logic                        o_scroll_req,
  output logic                        o_wr_en,
  output logic                        o_wr_blank,
  output logic [$clog2(COLUMNS)-1:0]  o_wr_col,
  output logic [$clog2(ROWS)-1:0]     o_wr_row
);

  localparam int COL_W = $clog2(COLUMNS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] w_col_nxt;
  logic [ROW_W-1:0] w_row_nxt;

  assign o_col = r_col;
  assign o_row = r_row;

  always_comb begin
    w_col_nxt    = r_col;
    w_row_nxt    = r_row;
    o_scroll_req = 1'b0;
    o_wr_en      = 1'b0;
    o_wr_blank   = 1'b0;
    o_wr_col     = r_col;
    o_wr_row     = r_row;
    if (i_step) begin
      case (i_class)
        CLS_PRINT: begin
          o_wr_en = 1'b1;
          if (r_col < LAST_COL) begin
            w_col_nxt = r_col + COL_W'(1);
          end else begin
            w_col_nxt = '0;
            if (r_row < LAST_ROW) w_row_nxt = r_row + ROW_W'(1);
            else                  o_scroll_req = 1'b1;
          end
        end
        CLS_LF: begin
          w_col_nxt = '0;
          if (r_row < LAST_ROW) w_row_nxt = r_row + ROW_W'(1);
          else                  o_scroll_req = 1'b1;
        end
        // Backspace blanks the cell the cursor lands on, wrapping to the previous row end.
        CLS_BS: begin
          if (r_col != '0) begin
            w_col_nxt  = r_col - COL_W'(1);
            o_wr_en    = 1'b1;
            o_wr_blank = 1'b1;
            o_wr_col   = r_col - COL_W'(1);
          end else if (r_row != '0) begin
            w_col_nxt  = LAST_COL;
            w_row_nxt  = r_row - ROW_W'(1);
            o_wr_en    = 1'b1;
            o_wr_blank = 1'b1;
            o_wr_col   = LAST_COL;
            o_wr_row   = r_row - ROW_W'(1);
          end
        end
        CLS_FF: begin
          w_col_nxt = '0;
          w_row_nxt = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

endmodule

// File: rtl/text_buffer_controller.sv
// rtl/text_buffer_controller.sv - terminal-style character buffer with cursor, scroll and clear sequencing
module text_buffer_controller
  import vga_text_pkg::*;
#(
  parameter int         COLUMNS    = 16,
  parameter int         ROWS       = 4,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [7:0]                   char_data,
  input  logic                         char_valid,
  output logic                         char_ready,
  output logic [COLUMNS*ROWS*8-1:0]    text_buffer,
  output logic [$clog2(COLUMNS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]      cursor_row,
  output logic                         busy
);

  localparam int NCELLS = COLUMNS * ROWS;
  localparam int IDX_W  = $clog2(NCELLS);
  localparam int COL_W  = $clog2(COLUMNS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCELLS - 1);
  localparam logic [IDX_W-1:0] SHIFT_END  = IDX_W'(COLUMNS * (ROWS - 1));
  localparam logic [IDX_W-1:0] ROW_STRIDE = IDX_W'(COLUMNS);

  txt_state_e       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_cell [NCELLS];

  logic             w_xfer;
  logic [2:0]       w_class;
  logic             w_scroll_req;
  logic             w_wr_en;
  logic             w_wr_blank;
  logic [COL_W-1:0] w_wr_col;
  logic [ROW_W-1:0] w_wr_row;
  logic [IDX_W-1:0] w_wr_addr;
  logic [7:0]       w_wr_data;
  logic [IDX_W-1:0] w_src_idx;

  assign char_ready = (r_state == IDLE);
  assign busy       = ~char_ready;
  assign w_xfer     = char_valid & char_ready;
  assign w_class    = classify(char_data);
  assign w_wr_addr  = IDX_W'(w_wr_row) * ROW_STRIDE + IDX_W'(w_wr_col);
  assign w_wr_data  = w_wr_blank ? BLANK_CHAR : char_data;
  // Only consulted while r_idx is below the last row, so it never points past the last cell.
  assign w_src_idx  = r_idx + ROW_STRIDE;

  text_cursor_tracker #(
    .COLUMNS (COLUMNS),
    .ROWS    (ROWS)
  ) u_cursor (
    .CLK          (CLK),
    .RST          (RST),
    .i_step       (w_xfer),
    .i_class      (w_class),
    .o_col        (cursor_col),
    .o_row        (cursor_row),
    .o_scroll_req (w_scroll_req),
    .o_wr_en      (w_wr_en),
    .o_wr_blank   (w_wr_blank),
    .o_wr_col     (w_wr_col),
    .o_wr_row     (w_wr_row)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_idx   <= '0;
      for (int i = 0; i < NCELLS; i++) r_cell[i] <= BLANK_CHAR;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (w_wr_en) r_cell[w_wr_addr] <= w_wr_data;
            r_idx <= '0;
            if (w_scroll_req)              r_state <= SCROLL;
            else if (w_class == CLS_FF)    r_state <= CLEAR;
          end
        end
        SCROLL: begin
          r_cell[r_idx] <= (r_idx < SHIFT_END) ? r_cell[w_src_idx] : BLANK_CHAR;
          r_idx         <= r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) r_state <= IDLE;
        end
        CLEAR: begin
          r_cell[r_idx] <= BLANK_CHAR;
          r_idx         <= r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLUMNS; gc++) begin : g_col
      assign text_buffer[cell_lsb(gr, gc, COLUMNS) +: 8] = r_cell[gr*COLUMNS + gc];
    end
  end

endmodule
